// File: rtl/phase_gen_pkg.sv
// Shared definitions for the phase generator and the trig stage it feeds.
package phase_gen_pkg;

  // Default theta width, shared with the trig stage so both agree on one source.
  localparam int unsigned PHASE_W = 32;
  // Default burst-length counter width.
  localparam int unsigned CNT_W   = 16;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

endpackage

// File: rtl/phase_gen.sv
// Phase accumulator producing theta[k] = offset + k*fcw (mod 2^D_WIDTH) over a
// valid/ready handshake, as a counted burst or a continuous stream.
module phase_gen
  import phase_gen_pkg::*;
#(
  parameter int unsigned D_WIDTH   = PHASE_W,
  parameter int unsigned CNT_WIDTH = CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic [D_WIDTH-1:0]   cfg_fcw,
  input  logic [D_WIDTH-1:0]   cfg_offset,
  input  logic [CNT_WIDTH-1:0] cfg_count,
  output logic [D_WIDTH-1:0]   theta,
  output logic                 theta_valid,
  input  logic                 theta_ready,
  output logic                 busy,
  output logic                 done
);

  state_t               state_q, state_d;
  logic [D_WIDTH-1:0]   acc_q, acc_d;
  logic [D_WIDTH-1:0]   fcw_q, fcw_d;
  logic [D_WIDTH-1:0]   offset_q, offset_d;
  logic [CNT_WIDTH-1:0] remaining_q, remaining_d;
  logic                 stop_pending_q, stop_pending_d;
  logic [D_WIDTH-1:0]   theta_q, theta_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 handshake;
  logic                 last_sample;
  logic [D_WIDTH-1:0]   acc_next;

  assign handshake = valid_q & theta_ready;
  // Continuous mode keeps remaining at 0, so it never reads as the last sample.
  assign last_sample = (remaining_q == CNT_WIDTH'(1));
  // Carry-out is dropped on purpose: phase wraps naturally.
  assign acc_next = acc_q + fcw_q;

  // Next-state and output decode; all outputs are taken from registers below.
  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    fcw_d          = fcw_q;
    offset_d       = offset_q;
    remaining_d    = remaining_q;
    stop_pending_d = stop_pending_q;
    theta_d        = theta_q;
    valid_d        = valid_q;
    busy_d         = busy_q;
    done_d         = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A simultaneous stop vetoes the start.
        if (start && !stop) begin
          fcw_d          = cfg_fcw;
          offset_d       = cfg_offset;
          remaining_d    = cfg_count;
          acc_d          = '0;
          theta_d        = cfg_offset;
          valid_d        = 1'b1;
          busy_d         = 1'b1;
          stop_pending_d = 1'b0;
          state_d        = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          stop_pending_d = 1'b1;
        end
        if (handshake) begin
          // A stop arriving with the handshake makes that sample the final one.
          if (last_sample || stop_pending_q || stop) begin
            valid_d        = 1'b0;
            busy_d         = 1'b0;
            done_d         = 1'b1;
            stop_pending_d = 1'b0;
            remaining_d    = '0;
            state_d        = IDLE;
          end else begin
            acc_d   = acc_next;
            theta_d = acc_next + offset_q;
            if (remaining_q != '0) begin
              remaining_d = remaining_q - CNT_WIDTH'(1);
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any burst without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      acc_q          <= '0;
      fcw_q          <= '0;
      offset_q       <= '0;
      remaining_q    <= '0;
      stop_pending_q <= 1'b0;
      theta_q        <= '0;
      valid_q        <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      fcw_q          <= fcw_d;
      offset_q       <= offset_d;
      remaining_q    <= remaining_d;
      stop_pending_q <= stop_pending_d;
      theta_q        <= theta_d;
      valid_q        <= valid_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign theta       = theta_q;
  assign theta_valid = valid_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: doc/phase_gen.md
Name: phase_gen

Overview:
- Upstream phase source for the trig lookup stage.
- Generates a burst (or continuous stream) of phase words theta[k] = offset + k*fcw, computed modulo 2^D_WIDTH.
- Theta is delivered over a valid/ready handshake so the downstream trig stage, or any pipeline register between the two, can apply backpressure.
- The burst is started by a single-cycle start strobe and reports completion with a one-cycle done pulse.

Parameters:
- D_WIDTH, 32, phase word width; must equal the trig stage's theta width.
- CNT_WIDTH, 16, width of the burst-length counter.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  start strobe; sampled only in IDLE.
- stop  in  1  stop request; sampled only in RUN.
- cfg_fcw  in  D_WIDTH  frequency control word (phase increment); latched on accepted start.
- cfg_offset  in  D_WIDTH  initial phase; latched on accepted start.
- cfg_count  in  CNT_WIDTH  number of samples; 0 means continuous; latched on accepted start.
- theta  out  D_WIDTH  phase word to the trig stage.
- theta_valid  out  1  theta holds a sample.
- theta_ready  in  1  downstream accepts the sample this cycle.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when the burst ends, whether by count or by stop.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - theta=0, theta_valid=0, busy=0, done=0.
  - Internal accumulator, latched fcw/offset and remaining count all cleared.
  - Reset asserted mid-burst aborts the burst immediately; no done pulse is issued.
- All outputs are registered.
- IDLE:
  - Accepted start = start=1 and stop=0 in the same cycle. If stop is also high, start is ignored and the block stays in IDLE.
  - On accepted start at edge t: latch fcw, offset and count; acc<=0; theta<=cfg_offset; theta_valid<=1; busy<=1; state<=RUN.
  - First sample is therefore visible in cycle t+1 (latency 1).
- RUN:
  - Handshake completes when theta_valid=1 and theta_ready=1.
  - While theta_valid=1 and theta_ready=0, theta must stay stable.
  - theta_valid never deasserts without a handshake, except on reset.
  - On handshake, when another sample is due: acc<=acc+fcw, theta<=acc+fcw+offset, theta_valid stays 1. Back-to-back samples are issued at one per cycle while theta_ready=1.
  - On handshake of the last sample (count mode, remaining count 1 → 0): theta_valid<=0, busy<=0, done<=1 for one cycle, state<=IDLE. theta keeps its last value.
  - Continuous mode (count=0): the remaining count is not decremented.
- Stop handling:
  - stop=1 in RUN sets stop_pending.
  - The sample currently presented is still delivered.
  - On its handshake, the burst ends exactly as for the last sample (done pulse, back to IDLE).
  - If stop and a handshake coincide, that handshake is the final one.
- Ignored inputs:
  - start in RUN is ignored.
  - Config inputs are ignored outside an accepted start, so mid-burst changes have no effect.
- Arithmetic:
  - Unsigned addition, modulo 2^D_WIDTH; carry-out is discarded, so phase wrap is natural.
  - The counter is unsigned, CNT_WIDTH wide.
- done may assert in the same cycle that a new start is presented. That start is accepted only once state=IDLE, i.e. from the cycle after the done pulse is registered.

Decomposition:
- Shared package phase_gen_pkg holds:
  - enum state_t {IDLE, RUN}.
  - Default width constants PHASE_W=32 and CNT_W=16, so the trig stage and this block share one source for theta width.
- No sub-module: the accumulator, counter and FSM are small enough to stay inline. Expected RTL is about 150 lines.

Test Plan (bench uses D_WIDTH=8, CNT_WIDTH=8):
- Basic burst: fcw=0x40, offset=0x10, count=4, theta_ready=1 → theta 0x10,0x50,0x90,0xD0 on consecutive cycles starting 1 cycle after start; done pulses with the last handshake; busy falls.
- Wrap-around: fcw=0xC0, offset=0x00, count=3 → 0x00,0xC0,0x80.
- Backpressure: count=3, fcw=0x01, offset=0x00, theta_ready low for 5 cycles on the 2nd sample → theta held at 0x01 with valid=1 throughout; the sequence completes as 0x00,0x01,0x02 with no loss or duplicate.
- Stop in continuous mode: count=0, fcw=0x10, offset=0x00, stop pulsed while theta=0x30 is presented with ready=0 → 0x30 is delivered once ready rises; no 0x40; done=1 for one cycle.
- Start+stop collision and ignored start: start and stop together in IDLE → nothing happens. A start pulse mid-burst → the sequence is unchanged.
- Reset mid-run: deassert rst_n after 2 samples → theta_valid, busy and done go to 0 asynchronously. A new start with offset=0x20 then yields 0x20 as its first sample.
